load_sequencer: RTL and testbench

Sequences the fetch of one tile set (A, B, optionally C) from memory over an AXI4 read master into the operand transform stage. It accepts one load command, issues one INCR read burst per matrix, and counts returned beats. Each beat is forwarded with the matching `burst_num`/`mat`/`data_type`/`rc` so the transform stage steers it into the SRAM banks or the systolic array. Sits between the command front-end and the transform/SRAM fill path.

---
 rtl/params.sv | 43 ++++
 rtl/beat_counter.sv | 26 ++
 rtl/load_sequencer.sv | 204 ++++++++++++++++++++
 tb/tb_load_sequencer.sv | 338 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/params.sv
// Shared definitions for the load path: operand/shape/matrix encodings, the
// sequencer state type, AXI constants and the per-matrix beat count table.
package params;

  typedef enum logic [1:0] {
    FP32 = 2'd0,
    FP16 = 2'd1,
    INT8 = 2'd2,
    INT4 = 2'd3
  } type_t;

  // Shape select; 2'b11 has no tile shape and is rejected.
  typedef logic [1:0] rc_t;
  localparam rc_t RC_M32N8   = 2'b00;
  localparam rc_t RC_M16N16  = 2'b01;
  localparam rc_t RC_M8N32   = 2'b10;
  localparam rc_t RC_ILLEGAL = 2'b11;

  typedef enum logic [1:0] {
    MAT_A = 2'd0,
    MAT_B = 2'd1,
    MAT_C = 2'd2
  } mat_t;

  typedef enum logic [2:0] {
    IDLE, AR_A, R_A, AR_B, R_B, AR_C, R_C, DONE
  } seq_state_t;

  localparam logic [2:0] AXI_SIZE_32B   = 3'd5;
  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

  // Beats of 32 B per matrix. Six bits because C needs 32; arlen and the
  // 5-bit last-beat index are both derived as beats-1.
  function automatic logic [5:0] beats(mat_t mat, type_t t);
    case (mat)
      MAT_A:   beats = (t == FP32) ? 6'd16 : 6'd8;
      MAT_B:   beats = (t == INT4) ? 6'd16 : 6'd8;
      default: beats = 6'd32;
    endcase
  endfunction

endpackage

// File: rtl/beat_counter.sv
// Beat counter for one read burst.
//   clk, rst_n : clock, async active-low reset
//   clr        : synchronous clear (held while the AR phase is active)
//   en         : count one R handshake
//   last_idx   : index of the final beat of the burst (beats-1)
//   cnt        : beats received so far in this burst
//   is_last    : the current beat is the final counted one
module beat_counter (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr,
  input  logic       en,
  input  logic [4:0] last_idx,
  output logic [4:0] cnt,
  output logic       is_last
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   cnt <= '0;
    else if (clr) cnt <= '0;
    else if (en)  cnt <= cnt + 5'd1;
  end

  assign is_last = (cnt == last_idx);

endmodule

// File: rtl/load_sequencer.sv
// Fetches one tile set (A, B, optional C) over an AXI4 read master, one INCR
// burst per matrix, and forwards each OKAY beat to the operand transform stage
// tagged with beat index, matrix, operand type and shape.
//   cmd_*        : load command in (valid/ready), type, shape, load_c, bases
//   m_ar* / m_r* : AXI4 read address / read data channels
//   trans_*      : registered beat + tags, trans_valid strobes once per beat
//   done / err   : one-cycle completion pulse, err qualified by done
module load_sequencer
  import params::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 256
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  type_t             cmd_type,
  input  rc_t               cmd_rc,
  input  logic              cmd_load_c,
  input  logic [ADDR_W-1:0] cmd_addr_a,
  input  logic [ADDR_W-1:0] cmd_addr_b,
  input  logic [ADDR_W-1:0] cmd_addr_c,
  output logic [ADDR_W-1:0] m_araddr,
  output logic [7:0]        m_arlen,
  output logic [2:0]        m_arsize,
  output logic [1:0]        m_arburst,
  output logic              m_arvalid,
  input  logic              m_arready,
  input  logic [DATA_W-1:0] m_rdata,
  input  logic [1:0]        m_rresp,
  input  logic              m_rlast,
  input  logic              m_rvalid,
  output logic              m_rready,
  output logic [DATA_W-1:0] trans_data,
  output logic [4:0]        trans_burst_num,
  output mat_t              trans_mat,
  output type_t             trans_type,
  output rc_t               trans_rc,
  output logic              trans_valid,
  output logic              done,
  output logic              err
);

  seq_state_t        state, state_nxt;
  type_t             type_q;
  rc_t               rc_q;
  logic              load_c_q;
  logic [ADDR_W-1:0] addr_a_q, addr_b_q, addr_c_q;
  logic              err_q;
  logic              bad_pend;   // illegal command accepted, DONE follows next cycle

  mat_t       cur_mat;
  logic [5:0] nbeats;
  logic [7:0] arlen_cur;
  logic [4:0] last_idx, beat_cnt;
  logic       is_last, in_ar, in_r;
  logic       cmd_acc, cmd_bad, r_hs, r_ok, burst_end, beat_err;

  assign m_arsize   = AXI_SIZE_32B;
  assign m_arburst  = AXI_BURST_INCR;
  assign trans_type = type_q;
  assign trans_rc   = rc_q;

  assign cmd_acc = cmd_valid && cmd_ready;
  assign cmd_bad = (cmd_rc == RC_ILLEGAL) || (cmd_addr_a[4:0] != 5'd0) ||
                   (cmd_addr_b[4:0] != 5'd0) ||
                   (cmd_load_c && (cmd_addr_c[4:0] != 5'd0));

  always_comb begin
    case (state)
      AR_B, R_B: cur_mat = MAT_B;
      AR_C, R_C: cur_mat = MAT_C;
      default:   cur_mat = MAT_A;
    endcase
  end

  assign nbeats    = beats(cur_mat, type_q);
  assign arlen_cur = {2'b00, nbeats - 6'd1};
  assign last_idx  = arlen_cur[4:0];
  assign in_ar     = (state == AR_A) || (state == AR_B) || (state == AR_C);
  assign in_r      = (state == R_A)  || (state == R_B)  || (state == R_C);

  assign r_hs      = m_rvalid && in_r;
  assign r_ok      = (m_rresp == AXI_RESP_OKAY);
  // Whichever of rlast / counted-last arrives first ends the burst; any
  // disagreement between them, or a non-OKAY beat, is recorded as an error.
  assign burst_end = r_hs && (is_last || m_rlast);
  assign beat_err  = r_hs && ((m_rlast != is_last) || !r_ok);

  beat_counter u_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (in_ar),
    .en       (r_hs),
    .last_idx (last_idx),
    .cnt      (beat_cnt),
    .is_last  (is_last)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    cmd_ready = 1'b0;
    m_arvalid = 1'b0;
    m_araddr  = '0;
    m_arlen   = '0;
    m_rready  = 1'b0;
    done      = 1'b0;
    err       = 1'b0;
    case (state)
      IDLE: begin
        cmd_ready = !bad_pend;
        if (bad_pend)                     state_nxt = DONE;
        else if (cmd_valid && !cmd_bad)   state_nxt = AR_A;
      end
      AR_A: begin
        m_arvalid = 1'b1;
        m_araddr  = addr_a_q;
        m_arlen   = arlen_cur;
        if (m_arready) state_nxt = R_A;
      end
      R_A: begin
        m_rready = 1'b1;
        if (burst_end) state_nxt = AR_B;
      end
      AR_B: begin
        m_arvalid = 1'b1;
        m_araddr  = addr_b_q;
        m_arlen   = arlen_cur;
        if (m_arready) state_nxt = R_B;
      end
      R_B: begin
        m_rready = 1'b1;
        if (burst_end) state_nxt = load_c_q ? AR_C : DONE;
      end
      AR_C: begin
        m_arvalid = 1'b1;
        m_araddr  = addr_c_q;
        m_arlen   = arlen_cur;
        if (m_arready) state_nxt = R_C;
      end
      R_C: begin
        m_rready = 1'b1;
        if (burst_end) state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        err       = err_q;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Command latch and sticky error.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      type_q   <= FP32;
      rc_q     <= RC_M32N8;
      load_c_q <= 1'b0;
      addr_a_q <= '0;
      addr_b_q <= '0;
      addr_c_q <= '0;
      bad_pend <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      bad_pend <= cmd_acc && cmd_bad;
      if (cmd_acc) begin
        type_q   <= cmd_type;
        rc_q     <= cmd_rc;
        load_c_q <= cmd_load_c;
        addr_a_q <= cmd_addr_a;
        addr_b_q <= cmd_addr_b;
        addr_c_q <= cmd_addr_c;
        err_q    <= cmd_bad;
      end else if (beat_err) begin
        err_q <= 1'b1;
      end
    end
  end

  // Beat forwarding; burst_num is the counter value before its increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      trans_valid     <= 1'b0;
      trans_data      <= '0;
      trans_burst_num <= '0;
      trans_mat       <= MAT_A;
    end else begin
      trans_valid <= r_hs && r_ok;
      if (r_hs && r_ok) begin
        trans_data      <= m_rdata;
        trans_burst_num <= beat_cnt;
        trans_mat       <= cur_mat;
      end
    end
  end

endmodule

// File: tb/tb_load_sequencer.sv
// Directed bench for load_sequencer: a simple AXI read slave, a queue-based
// model of the expected AR requests / forwarded beats / completion, and one
// negedge compare process.
module tb_load_sequencer;
  import params::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid, cmd_ready, cmd_load_c;
  type_t       cmd_type;
  rc_t         cmd_rc;
  logic [31:0] cmd_addr_a, cmd_addr_b, cmd_addr_c;
  logic [31:0] m_araddr;
  logic [7:0]  m_arlen;
  logic [2:0]  m_arsize;
  logic [1:0]  m_arburst, m_rresp;
  logic        m_arvalid, m_arready, m_rlast, m_rvalid, m_rready;
  logic [255:0] m_rdata, trans_data;
  logic [4:0]  trans_burst_num;
  mat_t        trans_mat;
  type_t       trans_type;
  rc_t         trans_rc;
  logic        trans_valid, done, err;

  always #5 clk = ~clk;

  load_sequencer #(.ADDR_W(32), .DATA_W(256)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_type(cmd_type),
    .cmd_rc(cmd_rc), .cmd_load_c(cmd_load_c),
    .cmd_addr_a(cmd_addr_a), .cmd_addr_b(cmd_addr_b), .cmd_addr_c(cmd_addr_c),
    .m_araddr(m_araddr), .m_arlen(m_arlen), .m_arsize(m_arsize),
    .m_arburst(m_arburst), .m_arvalid(m_arvalid), .m_arready(m_arready),
    .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rlast(m_rlast),
    .m_rvalid(m_rvalid), .m_rready(m_rready),
    .trans_data(trans_data), .trans_burst_num(trans_burst_num),
    .trans_mat(trans_mat), .trans_type(trans_type), .trans_rc(trans_rc),
    .trans_valid(trans_valid), .done(done), .err(err)
  );

  int total = 0;
  int bad = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // ---------------- model ----------------
  typedef struct packed {
    logic [255:0] data;
    logic [4:0]   num;
    mat_t         mat;
  } beat_t;

  beat_t       exp_q[$];
  logic [31:0] exp_ar_addr[$];
  logic [7:0]  exp_ar_len[$];
  logic [31:0] log_addr[$];
  logic [7:0]  log_len[$];
  int          trans_seen;
  bit          exp_err, exp_illegal;
  type_t       exp_type;
  rc_t         exp_rc;
  int          err_mat = -1, err_beat = -1, rl_mat = -1, rl_beat = -1;
  int          pl_cnt;
  logic [31:0] pl_addr[3];
  int          pl_send[3];

  function automatic int nbeats_of(int m, type_t t);
    if (m == 0) return (t == FP32) ? 16 : 8;
    if (m == 1) return (t == INT4) ? 16 : 8;
    return 32;
  endfunction

  function automatic logic [255:0] beat_data(logic [31:0] a, int i);
    logic [31:0] w;
    w = (a + 32'(i) * 32'd32) ^ 32'hA5A5_0000;
    return {8{w}};
  endfunction

  task automatic plan(input type_t t, input rc_t rc, input bit lc,
                      input logic [31:0] aa, input logic [31:0] ab, input logic [31:0] ac);
    logic [31:0] ad[3];
    int n, ns;
    beat_t b;
    ad[0] = aa; ad[1] = ab; ad[2] = ac;
    exp_type = t;
    exp_rc   = rc;
    exp_illegal = (rc == 2'b11) || (aa[4:0] != 0) || (ab[4:0] != 0) || (lc && ac[4:0] != 0);
    exp_err  = exp_illegal || (err_mat >= 0) || (rl_mat >= 0);
    pl_cnt   = exp_illegal ? 0 : (lc ? 3 : 2);
    for (int m = 0; m < pl_cnt; m++) begin
      n  = nbeats_of(m, t);
      ns = (m == rl_mat) ? rl_beat + 1 : n;
      pl_addr[m] = ad[m];
      pl_send[m] = ns;
      exp_ar_addr.push_back(ad[m]);
      exp_ar_len.push_back(8'(n - 1));
      for (int i = 0; i < ns; i++) begin
        if (!(m == err_mat && i == err_beat)) begin
          b.data = beat_data(ad[m], i);
          b.num  = 5'(i);
          b.mat  = mat_t'(m);
          exp_q.push_back(b);
        end
      end
    end
  endtask

  // ---------------- compare process ----------------
  bit          exp_tv, busy, ar_wait;
  logic [31:0] ar_a_prev;
  logic [7:0]  ar_l_prev;
  int          acc_cyc, rl_cyc;
  beat_t       e_b;

  always @(negedge clk) begin
    if (!rst_n) begin
      exp_tv = 0; busy = 0; ar_wait = 0;
    end else begin
      chk("cmd_ready", cmd_ready, !busy);
      chk("trans_valid", trans_valid, exp_tv);
      if (trans_valid) begin
        trans_seen++;
        if (exp_q.size() == 0) chk("trans_extra", trans_valid, 0);
        else begin
          e_b = exp_q.pop_front();
          chk("trans_data", trans_data, e_b.data);
          chk("trans_burst_num", trans_burst_num, e_b.num);
          chk("trans_mat", trans_mat, e_b.mat);
          chk("trans_type", trans_type, exp_type);
          chk("trans_rc", trans_rc, exp_rc);
        end
      end
      if (ar_wait) begin
        chk("ar_hold_valid", m_arvalid, 1);
        chk("ar_hold_addr", m_araddr, ar_a_prev);
        chk("ar_hold_len", m_arlen, ar_l_prev);
      end
      if (m_arvalid && exp_ar_addr.size() == 0) chk("ar_unexpected", m_arvalid, 0);
      if (m_arvalid && m_arready && exp_ar_addr.size() != 0) begin
        log_addr.push_back(m_araddr);
        log_len.push_back(m_arlen);
        chk("araddr", m_araddr, exp_ar_addr.pop_front());
        chk("arlen", m_arlen, exp_ar_len.pop_front());
        chk("arsize", m_arsize, 3'd5);
        chk("arburst", m_arburst, 2'b01);
      end
      ar_wait   = m_arvalid && !m_arready;
      ar_a_prev = m_araddr;
      ar_l_prev = m_arlen;
      if (m_rvalid && m_rready && m_rlast) rl_cyc = cyc;
      if (cmd_valid && cmd_ready) begin acc_cyc = cyc; busy = 1; end
      if (done) begin
        chk("done_err", err, exp_err);
        chk("done_time", cyc, exp_illegal ? acc_cyc + 2 : rl_cyc + 1);
        busy = 0;
      end
      exp_tv = m_rvalid && m_rready && (m_rresp == 2'b00);
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick;
    @(posedge clk); #1;
  endtask

  task automatic send_cmd(input type_t t, input rc_t rc, input bit lc,
                          input logic [31:0] aa, input logic [31:0] ab, input logic [31:0] ac);
    int w = 0;
    cmd_type = t; cmd_rc = rc; cmd_load_c = lc;
    cmd_addr_a = aa; cmd_addr_b = ab; cmd_addr_c = ac;
    cmd_valid = 1;
    while (!cmd_ready && w < 20) begin tick(); w++; end
    chk("cmd_accept_timeout", cmd_ready, 1);
    tick();
    cmd_valid = 0;
  endtask

  task automatic do_ar(input int dly);
    int w = 0;
    while (!m_arvalid && w < 100) begin tick(); w++; end
    chk("ar_timeout", m_arvalid, 1);
    repeat (dly) tick();
    m_arready = 1;
    tick();
    m_arready = 0;
  endtask

  // Send the beats of burst m; stop >= 0 truncates without rlast.
  task automatic do_r(input int m, input bit gaps, input int stop);
    int w;
    int n = (stop >= 0) ? stop : pl_send[m];
    for (int i = 0; i < n; i++) begin
      if (gaps && i > 0) begin m_rvalid = 0; m_rlast = 0; tick(); end
      m_rvalid = 1;
      m_rdata  = beat_data(pl_addr[m], i);
      m_rresp  = (m == err_mat && i == err_beat) ? 2'b10 : 2'b00;
      m_rlast  = (i == pl_send[m] - 1);
      w = 0;
      while (!m_rready && w < 50) begin tick(); w++; end
      chk("rready_timeout", m_rready, 1);
      tick();
    end
    m_rvalid = 0; m_rlast = 0; m_rresp = 0;
  endtask

  task automatic wait_done;
    int w = 0;
    while (!done && w < 200) begin tick(); w++; end
    chk("done_timeout", done, 1);
    tick();
  endtask

  task automatic run_cmd(input type_t t, input rc_t rc, input bit lc,
                         input logic [31:0] aa, input logic [31:0] ab, input logic [31:0] ac,
                         input int dly, input bit gaps);
    log_addr.delete(); log_len.delete(); trans_seen = 0;
    plan(t, rc, lc, aa, ab, ac);
    send_cmd(t, rc, lc, aa, ab, ac);
    for (int m = 0; m < pl_cnt; m++) begin
      do_ar(dly);
      do_r(m, gaps, -1);
    end
    wait_done();
    chk("leftover_beats", exp_q.size(), 0);
    chk("leftover_ars", exp_ar_addr.size(), 0);
    err_mat = -1; err_beat = -1; rl_mat = -1; rl_beat = -1;
  endtask

  task automatic check_reset(input string p);
    chk({p, "_cmd_ready"}, cmd_ready, 1);
    chk({p, "_arvalid"}, m_arvalid, 0);
    chk({p, "_rready"}, m_rready, 0);
    chk({p, "_araddr"}, m_araddr, 0);
    chk({p, "_arlen"}, m_arlen, 0);
    chk({p, "_trans_valid"}, trans_valid, 0);
    chk({p, "_trans_data"}, trans_data, 0);
    chk({p, "_burst_num"}, trans_burst_num, 0);
    chk({p, "_trans_mat"}, trans_mat, MAT_A);
    chk({p, "_trans_type"}, trans_type, FP32);
    chk({p, "_trans_rc"}, trans_rc, 0);
    chk({p, "_done"}, done, 0);
    chk({p, "_err"}, err, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    cmd_valid = 0; cmd_type = FP32; cmd_rc = 0; cmd_load_c = 0;
    cmd_addr_a = 0; cmd_addr_b = 0; cmd_addr_c = 0;
    m_arready = 0; m_rdata = 0; m_rresp = 0; m_rlast = 0; m_rvalid = 0;
    #12;
    check_reset("por");
    tick();
    rst_n = 1;

    // FP16 M16N16, A and B only
    run_cmd(FP16, 2'b01, 0, 32'h1000, 32'h2000, 32'h0, 0, 0);
    chk("t1_ar_count", log_addr.size(), 2);
    if (log_addr.size() == 2) begin
      chk("t1_a_addr", log_addr[0], 32'h1000);
      chk("t1_a_len", log_len[0], 8'd7);
      chk("t1_b_addr", log_addr[1], 32'h2000);
      chk("t1_b_len", log_len[1], 8'd7);
    end
    chk("t1_trans", trans_seen, 16);

    // FP32 with C, arready held low 5 cycles on each AR
    run_cmd(FP32, 2'b00, 1, 32'h3000, 32'h3400, 32'h3800, 5, 0);
    chk("t2_ar_count", log_len.size(), 3);
    if (log_len.size() == 3) begin
      chk("t2_a_len", log_len[0], 8'd15);
      chk("t2_b_len", log_len[1], 8'd7);
      chk("t2_c_len", log_len[2], 8'd31);
      chk("t2_c_addr", log_addr[2], 32'h3800);
    end
    chk("t2_trans", trans_seen, 56);

    // INT4 with rvalid gaps
    run_cmd(INT4, 2'b10, 0, 32'h6000, 32'h7000, 32'h0, 1, 1);
    chk("t3_ar_count", log_len.size(), 2);
    if (log_len.size() == 2) chk("t3_b_len", log_len[1], 8'd15);
    chk("t3_trans", trans_seen, 24);

    // SLVERR on A beat 3
    err_mat = 0; err_beat = 3;
    run_cmd(INT8, 2'b01, 0, 32'h8000, 32'h9000, 32'h0, 0, 0);
    chk("t4_ar_count", log_len.size(), 2);
    chk("t4_trans", trans_seen, 15);

    // early rlast on A beat 5 of 8
    rl_mat = 0; rl_beat = 5;
    run_cmd(FP16, 2'b00, 0, 32'hA000, 32'hB000, 32'h0, 0, 0);
    chk("t5_ar_count", log_len.size(), 2);
    chk("t5_trans", trans_seen, 14);

    // illegal shape, then misaligned address
    run_cmd(FP32, 2'b11, 0, 32'h1000, 32'h2000, 32'h0, 0, 0);
    chk("t6_ar_count", log_len.size(), 0);
    run_cmd(INT8, 2'b00, 1, 32'h1000, 32'h2000, 32'h3010, 0, 0);
    chk("t7_ar_count", log_len.size(), 0);

    // reset in the middle of R_B
    log_addr.delete(); log_len.delete();
    plan(FP32, 2'b00, 0, 32'h4000, 32'h5000, 32'h0);
    send_cmd(FP32, 2'b00, 0, 32'h4000, 32'h5000, 32'h0);
    do_ar(0);
    do_r(0, 0, -1);
    do_ar(0);
    do_r(1, 0, 3);
    #2 rst_n = 0;
    #1 check_reset("midrst");
    exp_q.delete(); exp_ar_addr.delete(); exp_ar_len.delete();
    tick(); tick();
    rst_n = 1;

    // clean command after reset
    run_cmd(FP32, 2'b10, 1, 32'hC000, 32'hD000, 32'hE000, 2, 0);
    chk("t8_ar_count", log_len.size(), 3);
    chk("t8_trans", trans_seen, 56);

    repeat (3) tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
